// File: rtl/dma_avmm_arbiter_if.sv
// rtl/dma_avmm_arbiter_if.sv - Requester and Avalon-MM master signal bundle for dma_avmm_arbiter
interface dma_avmm_arbiter_if #(
  parameter int DATA_W   = 256,
  parameter int ADDR_W   = 32,
  parameter int BCOUNT_W = 11
);
  logic                rd_req_i;
  logic [ADDR_W-1:0]   rd_addr_i;
  logic [BCOUNT_W-1:0] rd_bcount_i;
  logic                rd_gnt_o;
  logic [DATA_W-1:0]   rd_readdata_o;
  logic                rd_readdatavalid_o;
  logic                rd_done_o;

  logic                wr_req_i;
  logic [ADDR_W-1:0]   wr_addr_i;
  logic [BCOUNT_W-1:0] wr_bcount_i;
  logic [DATA_W-1:0]   wr_data_i;
  logic                wr_valid_i;
  logic                wr_ready_o;
  logic                wr_gnt_o;
  logic                wr_done_o;

  logic [ADDR_W-1:0]   avm_address_o;
  logic [BCOUNT_W-1:0] avm_burstcount_o;
  logic                avm_read_o;
  logic                avm_write_o;
  logic [DATA_W-1:0]   avm_writedata_o;
  logic                avm_waitrequest_i;
  logic [DATA_W-1:0]   avm_readdata_i;
  logic                avm_readdatavalid_i;

  // Arbiter side
  modport slave (
    input  rd_req_i, rd_addr_i, rd_bcount_i,
    output rd_gnt_o, rd_readdata_o, rd_readdatavalid_o, rd_done_o,
    input  wr_req_i, wr_addr_i, wr_bcount_i, wr_data_i, wr_valid_i,
    output wr_ready_o, wr_gnt_o, wr_done_o,
    output avm_address_o, avm_burstcount_o, avm_read_o, avm_write_o, avm_writedata_o,
    input  avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i
  );

  // Requesters plus external slave side
  modport master (
    output rd_req_i, rd_addr_i, rd_bcount_i,
    input  rd_gnt_o, rd_readdata_o, rd_readdatavalid_o, rd_done_o,
    output wr_req_i, wr_addr_i, wr_bcount_i, wr_data_i, wr_valid_i,
    input  wr_ready_o, wr_gnt_o, wr_done_o,
    input  avm_address_o, avm_burstcount_o, avm_read_o, avm_write_o, avm_writedata_o,
    output avm_waitrequest_i, avm_readdata_i, avm_readdatavalid_i
  );
endinterface

// File: rtl/dma_avmm_arbiter.sv
// rtl/dma_avmm_arbiter.sv - Two-requester burst arbiter in front of one Avalon-MM master
module dma_avmm_arbiter #(
  parameter int DATA_W      = 256,
  parameter int ADDR_W      = 32,
  parameter int BCOUNT_W    = 11,
  parameter int WR_PRIORITY = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  dma_avmm_arbiter_if.slave    bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_CMD  = 3'd1,
    RD_DATA = 3'd2,
    WR_XFR  = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [BCOUNT_W-1:0] ONE = BCOUNT_W'(1);

  state_t              state;
  state_t              state_nxt;
  logic                owner_wr;
  logic                last_gnt_wr;
  logic [BCOUNT_W-1:0] beat_cnt;
  logic [BCOUNT_W-1:0] bcount_q;
  logic [ADDR_W-1:0]   addr_q;

  logic                any_req;
  logic                sel_wr;
  logic [BCOUNT_W-1:0] sel_bcount;
  logic                rd_beat;
  logic                wr_beat;

  always_comb begin
    any_req    = bus.rd_req_i | bus.wr_req_i;
    // Write wins when alone, when prioritised, or when read had the previous grant.
    sel_wr     = bus.wr_req_i &
                 (!bus.rd_req_i || (WR_PRIORITY != 0) || !last_gnt_wr);
    sel_bcount = sel_wr ? bus.wr_bcount_i : bus.rd_bcount_i;
    rd_beat    = (state == RD_DATA) && bus.avm_readdatavalid_i;
    wr_beat    = (state == WR_XFR) && bus.wr_valid_i && !bus.avm_waitrequest_i;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (sel_bcount == '0) begin
            state_nxt = DONE;
          end else if (sel_wr) begin
            state_nxt = WR_XFR;
          end else begin
            state_nxt = RD_CMD;
          end
        end
      end
      RD_CMD: begin
        if (!bus.avm_waitrequest_i) begin
          state_nxt = RD_DATA;
        end
      end
      RD_DATA: begin
        if (rd_beat && (beat_cnt == ONE)) begin
          state_nxt = DONE;
        end
      end
      WR_XFR: begin
        if (wr_beat && (beat_cnt == ONE)) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_wr    <= 1'b0;
      last_gnt_wr <= 1'b1;
      beat_cnt    <= '0;
      bcount_q    <= '0;
      addr_q      <= '0;
    end else begin
      if ((state == IDLE) && any_req) begin
        owner_wr <= sel_wr;
        addr_q   <= sel_wr ? bus.wr_addr_i : bus.rd_addr_i;
        bcount_q <= sel_bcount;
        beat_cnt <= sel_bcount;
      end else if (rd_beat || wr_beat) begin
        beat_cnt <= beat_cnt - ONE;
      end
      if (state == DONE) begin
        last_gnt_wr <= owner_wr;
      end
    end
  end

  always_comb begin
    bus.rd_gnt_o           = 1'b0;
    bus.wr_gnt_o           = 1'b0;
    bus.rd_readdata_o      = '0;
    bus.rd_readdatavalid_o = 1'b0;
    bus.rd_done_o          = 1'b0;
    bus.wr_ready_o         = 1'b0;
    bus.wr_done_o          = 1'b0;
    bus.avm_read_o         = 1'b0;
    bus.avm_write_o        = 1'b0;
    bus.avm_writedata_o    = '0;
    bus.avm_address_o      = addr_q;
    bus.avm_burstcount_o   = bcount_q;
    case (state)
      RD_CMD: begin
        bus.rd_gnt_o   = 1'b1;
        bus.avm_read_o = 1'b1;
      end
      RD_DATA: begin
        bus.rd_gnt_o           = 1'b1;
        bus.rd_readdatavalid_o = bus.avm_readdatavalid_i;
        bus.rd_readdata_o      = bus.avm_readdata_i;
      end
      WR_XFR: begin
        bus.wr_gnt_o        = 1'b1;
        bus.avm_write_o     = bus.wr_valid_i;
        bus.avm_writedata_o = bus.wr_data_i;
        bus.wr_ready_o      = bus.wr_valid_i & !bus.avm_waitrequest_i;
      end
      DONE: begin
        bus.rd_gnt_o  = !owner_wr;
        bus.rd_done_o = !owner_wr;
        bus.wr_gnt_o  = owner_wr;
        bus.wr_done_o = owner_wr;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dma_avmm_arbiter.sv
// tb/tb_dma_avmm_arbiter.sv - Directed self-checking bench for dma_avmm_arbiter
module tb_dma_avmm_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dma_avmm_arbiter_if #(.DATA_W(256), .ADDR_W(32), .BCOUNT_W(11)) ia ();
  dma_avmm_arbiter_if #(.DATA_W(256), .ADDR_W(32), .BCOUNT_W(11)) ib ();

  dma_avmm_arbiter #(.DATA_W(256), .ADDR_W(32), .BCOUNT_W(11), .WR_PRIORITY(0)) dut_rr (
    .clk   (clk),
    .reset (reset),
    .bus   (ia)
  );

  dma_avmm_arbiter #(.DATA_W(256), .ADDR_W(32), .BCOUNT_W(11), .WR_PRIORITY(1)) dut_pr (
    .clk   (clk),
    .reset (reset),
    .bus   (ib)
  );

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] seed);
    return {8{seed}};
  endfunction

  initial begin
    ia.rd_req_i = 0; ia.rd_addr_i = 0; ia.rd_bcount_i = 0;
    ia.wr_req_i = 0; ia.wr_addr_i = 0; ia.wr_bcount_i = 0;
    ia.wr_data_i = 0; ia.wr_valid_i = 0;
    ia.avm_waitrequest_i = 0; ia.avm_readdata_i = 0; ia.avm_readdatavalid_i = 0;
    ib.rd_req_i = 0; ib.rd_addr_i = 0; ib.rd_bcount_i = 0;
    ib.wr_req_i = 0; ib.wr_addr_i = 0; ib.wr_bcount_i = 0;
    ib.wr_data_i = 0; ib.wr_valid_i = 0;
    ib.avm_waitrequest_i = 0; ib.avm_readdata_i = 0; ib.avm_readdatavalid_i = 0;

    // Reset state
    nxt(); nxt();
    ia.avm_readdatavalid_i = 1; ia.avm_readdata_i = pat(32'hDEAD0000);
    smp();
    chk("rst_rd_gnt", ia.rd_gnt_o, 0);
    chk("rst_wr_gnt", ia.wr_gnt_o, 0);
    chk("rst_avm_read", ia.avm_read_o, 0);
    chk("rst_avm_write", ia.avm_write_o, 0);
    chk("rst_address", ia.avm_address_o, 0);
    chk("rst_burstcount", ia.avm_burstcount_o, 0);
    chk("rst_rdv_dropped", ia.rd_readdatavalid_o, 0);
    chk("rst_pr_gnt", {ib.rd_gnt_o, ib.wr_gnt_o}, 0);

    // 1: read only, 4 beats, 2 waitrequest cycles
    nxt(); reset = 0; ia.avm_readdatavalid_i = 0; ia.avm_readdata_i = 0;
    ia.rd_req_i = 1; ia.rd_addr_i = 32'h1000; ia.rd_bcount_i = 4; ia.avm_waitrequest_i = 1;
    smp(); chk("t1_gnt_in_idle", ia.rd_gnt_o, 0);
    nxt(); smp();
    chk("t1_rd_gnt", ia.rd_gnt_o, 1);
    chk("t1_read_w1", ia.avm_read_o, 1);
    chk("t1_address", ia.avm_address_o, 32'h1000);
    chk("t1_burstcount", ia.avm_burstcount_o, 4);
    nxt(); smp(); chk("t1_read_w2", ia.avm_read_o, 1);
    nxt(); ia.avm_waitrequest_i = 0; smp(); chk("t1_read_acc", ia.avm_read_o, 1);
    nxt(); ia.avm_readdatavalid_i = 1; ia.avm_readdata_i = pat(32'hA0000000);
    smp(); chk("t1_read_dropped", ia.avm_read_o, 0);
    chk("t1_rdv0", ia.rd_readdatavalid_o, 1); chk("t1_data0", ia.rd_readdata_o, pat(32'hA0000000));
    nxt(); ia.avm_readdatavalid_i = 0; smp(); chk("t1_gap", ia.rd_readdatavalid_o, 0);
    nxt(); ia.avm_readdatavalid_i = 1; ia.avm_readdata_i = pat(32'hA0000001);
    smp(); chk("t1_data1", ia.rd_readdata_o, pat(32'hA0000001));
    nxt(); ia.avm_readdata_i = pat(32'hA0000002);
    smp(); chk("t1_data2", ia.rd_readdata_o, pat(32'hA0000002));
    nxt(); ia.avm_readdatavalid_i = 0;
    nxt(); ia.avm_readdatavalid_i = 1; ia.avm_readdata_i = pat(32'hA0000003);
    smp(); chk("t1_data3", ia.rd_readdata_o, pat(32'hA0000003)); chk("t1_no_early_done", ia.rd_done_o, 0);
    nxt(); ia.avm_readdatavalid_i = 0; ia.rd_req_i = 0;
    smp(); chk("t1_rd_done", ia.rd_done_o, 1); chk("t1_gnt_done", ia.rd_gnt_o, 1);
    nxt(); smp(); chk("t1_done_pulse", ia.rd_done_o, 0); chk("t1_gnt_off", ia.rd_gnt_o, 0);

    // 2: write only, 3 beats, gapped valid and toggling waitrequest
    ia.wr_req_i = 1; ia.wr_addr_i = 32'h2000; ia.wr_bcount_i = 3;
    nxt(); smp();
    chk("t2_wr_gnt", ia.wr_gnt_o, 1); chk("t2_write_novalid", ia.avm_write_o, 0);
    chk("t2_address", ia.avm_address_o, 32'h2000); chk("t2_burstcount", ia.avm_burstcount_o, 3);
    nxt(); ia.wr_valid_i = 1; ia.wr_data_i = pat(32'hB0000000); ia.avm_waitrequest_i = 1;
    smp(); chk("t2_write_w", ia.avm_write_o, 1); chk("t2_ready_w", ia.wr_ready_o, 0);
    chk("t2_wdata0", ia.avm_writedata_o, pat(32'hB0000000));
    nxt(); ia.avm_waitrequest_i = 0; smp(); chk("t2_ready0", ia.wr_ready_o, 1);
    nxt(); ia.wr_data_i = pat(32'hB0000001);
    smp(); chk("t2_ready1", ia.wr_ready_o, 1); chk("t2_wdata1", ia.avm_writedata_o, pat(32'hB0000001));
    nxt(); ia.wr_valid_i = 0; smp(); chk("t2_gap_write", ia.avm_write_o, 0); chk("t2_gap_ready", ia.wr_ready_o, 0);
    nxt(); ia.wr_valid_i = 1; ia.wr_data_i = pat(32'hB0000002); ia.avm_waitrequest_i = 1;
    smp(); chk("t2_ready_w2", ia.wr_ready_o, 0); chk("t2_addr_held", ia.avm_address_o, 32'h2000);
    nxt(); ia.avm_waitrequest_i = 0;
    smp(); chk("t2_ready2", ia.wr_ready_o, 1); chk("t2_no_early_done", ia.wr_done_o, 0);
    nxt(); ia.wr_req_i = 0;
    smp(); chk("t2_wr_done", ia.wr_done_o, 1); chk("t2_write_in_done", ia.avm_write_o, 0);
    chk("t2_gnt_done", ia.wr_gnt_o, 1);
    ia.wr_valid_i = 0;
    nxt(); smp(); chk("t2_done_pulse", ia.wr_done_o, 0);

    // 3: both requests after reset, round-robin
    nxt(); reset = 1;
    nxt(); reset = 0;
    ia.rd_req_i = 1; ia.rd_addr_i = 32'h3000; ia.rd_bcount_i = 1;
    ia.wr_req_i = 1; ia.wr_addr_i = 32'h4000; ia.wr_bcount_i = 1;
    ia.wr_valid_i = 1; ia.wr_data_i = pat(32'hC0000000);
    nxt(); smp();
    chk("t3_first_rd", ia.rd_gnt_o, 1); chk("t3_first_not_wr", ia.wr_gnt_o, 0);
    chk("t3_first_addr", ia.avm_address_o, 32'h3000);
    nxt(); ia.avm_readdatavalid_i = 1; ia.avm_readdata_i = pat(32'hC0000001);
    smp(); chk("t3_rdv", ia.rd_readdatavalid_o, 1);
    nxt(); ia.avm_readdatavalid_i = 0; smp(); chk("t3_rd_done", ia.rd_done_o, 1);
    nxt(); smp(); chk("t3_idle_gnt", {ia.rd_gnt_o, ia.wr_gnt_o}, 0);
    nxt(); smp();
    chk("t3_second_wr", ia.wr_gnt_o, 1); chk("t3_second_not_rd", ia.rd_gnt_o, 0);
    chk("t3_second_addr", ia.avm_address_o, 32'h4000); chk("t3_wr_ready", ia.wr_ready_o, 1);
    nxt(); smp(); chk("t3_wr_done", ia.wr_done_o, 1);
    nxt(); nxt(); smp();
    chk("t3_third_rd", ia.rd_gnt_o, 1); chk("t3_third_not_wr", ia.wr_gnt_o, 0);
    nxt(); ia.avm_readdatavalid_i = 1; ia.rd_req_i = 0; ia.wr_req_i = 0; ia.wr_valid_i = 0;
    nxt(); ia.avm_readdatavalid_i = 0; smp(); chk("t3_third_done", ia.rd_done_o, 1);
    nxt();

    // 4: write priority instance, both requesting continuously
    ib.wr_req_i = 1; ib.wr_addr_i = 32'h6000; ib.wr_bcount_i = 1;
    ib.wr_valid_i = 1; ib.wr_data_i = pat(32'hD0000000);
    ib.rd_req_i = 1; ib.rd_addr_i = 32'h7000; ib.rd_bcount_i = 0;
    nxt(); smp(); chk("t4_tie1_wr", ib.wr_gnt_o, 1); chk("t4_tie1_rd", ib.rd_gnt_o, 0);
    nxt(); smp(); chk("t4_done1", ib.wr_done_o, 1);
    nxt(); nxt(); smp(); chk("t4_tie2_wr", ib.wr_gnt_o, 1); chk("t4_tie2_rd", ib.rd_gnt_o, 0);
    nxt(); ib.wr_req_i = 0; ib.wr_valid_i = 0; smp(); chk("t4_done2", ib.wr_done_o, 1);
    nxt(); nxt(); smp();
    chk("t4_rd_served", ib.rd_gnt_o, 1); chk("t4_rd_done", ib.rd_done_o, 1);
    chk("t4_rd_no_read", ib.avm_read_o, 0);
    ib.rd_req_i = 0;
    nxt();

    // 5: zero-length write
    ia.wr_req_i = 1; ia.wr_addr_i = 32'h8000; ia.wr_bcount_i = 0;
    ia.wr_valid_i = 1; ia.wr_data_i = pat(32'hE0000000);
    nxt(); ia.wr_req_i = 0;
    smp();
    chk("t5_gnt", ia.wr_gnt_o, 1); chk("t5_done", ia.wr_done_o, 1);
    chk("t5_no_write", ia.avm_write_o, 0); chk("t5_no_ready", ia.wr_ready_o, 0);
    nxt(); ia.wr_valid_i = 0; smp(); chk("t5_idle", {ia.wr_gnt_o, ia.wr_done_o}, 0);

    // 6: reset mid read burst
    ia.rd_req_i = 1; ia.rd_addr_i = 32'h5000; ia.rd_bcount_i = 8;
    nxt(); smp(); chk("t6_read", ia.avm_read_o, 1);
    nxt(); ia.avm_readdatavalid_i = 1; ia.avm_readdata_i = pat(32'hF0000000);
    smp(); chk("t6_beat0", ia.rd_readdatavalid_o, 1);
    nxt(); ia.avm_readdata_i = pat(32'hF0000001);
    smp(); chk("t6_beat1", ia.rd_readdata_o, pat(32'hF0000001));
    nxt(); reset = 1; ia.rd_req_i = 0; ia.avm_readdatavalid_i = 0;
    nxt(); reset = 0; ia.avm_readdatavalid_i = 1; ia.avm_readdata_i = pat(32'hF0000002);
    smp();
    chk("t6_gnt_off", ia.rd_gnt_o, 0); chk("t6_no_done", ia.rd_done_o, 0);
    chk("t6_late_rdv", ia.rd_readdatavalid_o, 0);
    nxt(); smp(); chk("t6_late_rdv2", ia.rd_readdatavalid_o, 0); chk("t6_no_done2", ia.rd_done_o, 0);
    ia.avm_readdatavalid_i = 0;
    ia.rd_req_i = 1; ia.rd_addr_i = 32'h9000; ia.rd_bcount_i = 1;
    nxt(); smp(); chk("t6_new_gnt", ia.rd_gnt_o, 1); chk("t6_new_addr", ia.avm_address_o, 32'h9000);
    nxt(); ia.avm_readdatavalid_i = 1; ia.avm_readdata_i = pat(32'hF0000003);
    smp(); chk("t6_new_data", ia.rd_readdata_o, pat(32'hF0000003));
    nxt(); ia.avm_readdatavalid_i = 0; ia.rd_req_i = 0;
    smp(); chk("t6_new_done", ia.rd_done_o, 1);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
